data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters (name, default, meaning):
- DEPTH_WORDS, 1024, RAM size in 32-bit words; power of two.
- FIFO_DEPTH, 8, console FIFO entries; power of two, at least 2.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- d_mem_addr, in, 32, byte address from CPU.
- d_mem_wdata, in, 32, store data.
- d_mem_wen, in, 4, byte write enables; 0 means read-only cycle.
- d_mem_rdata, out, 32, read data.
- con_valid, out, 1, console byte available.
- con_data, out, 8, console byte.
- con_ready, in, 1, console sink accepts byte.
- tohost_valid, out, 1, test-finished flag.
- tohost_data, out, 32, captured TOHOST value.
- bad_addr, out, 1, sticky unmapped-access flag.

Function
REQ-004 The address map SHALL be:
- RAM at 0x0000_0000 .. DEPTH_WORDS*4-1.
- CON_TX at 0x1000_0000.
- CON_STATUS at 0x1000_0004.
- CYCLE_LO at 0x1000_0008.
- CYCLE_HI at 0x1000_000C.
- TOHOST at 0x1000_0010.
REQ-005 d_mem_addr[1:0] SHALL be ignored; all accesses are word-aligned.
REQ-006 Every cycle is a read of d_mem_addr; d_mem_rdata SHALL present that word exactly 1 cycle later (registered read).
REQ-007 A RAM write SHALL update only the bytes whose d_mem_wen bit is 1, taking byte i from d_mem_wdata[8i+7:8i].
REQ-008 Read and write to the same RAM word in one cycle SHALL be read-first: rdata returns the pre-write contents.
REQ-009 A write to CON_TX with d_mem_wen[0]=1 SHALL push d_mem_wdata[7:0] into the console FIFO, unless the FIFO is full and no pop occurs that cycle.
REQ-010 A push rejected under REQ-009 SHALL drop the byte and set the sticky overflow bit.
REQ-011 Console output SHALL use a valid/ready handshake:
- con_valid = FIFO not empty; con_data = head entry (combinational from FIFO state).
- Pop occurs when con_valid && con_ready.
- con_data stays stable while con_valid is 1 and con_ready is 0.
REQ-012 Simultaneous push and pop SHALL leave the count unchanged. On an empty FIFO, the pushed byte appears on con_valid one cycle later; there is no fall-through.
REQ-013 A CON_STATUS read SHALL return:
- bit0 = full.
- bit1 = empty.
- bit2 = overflow (sticky).
- bits[7:4] = count, saturating at 15.
- all other bits 0.
Writing 1 to bit2 of CON_STATUS SHALL clear overflow.
REQ-014 A 64-bit cycle counter SHALL increment every cycle and wrap from 2^64-1 to 0.
REQ-015 Reading CYCLE_LO SHALL return counter[31:0] and snapshot counter[63:32]. Reading CYCLE_HI SHALL return that snapshot. Writes to both SHALL be ignored.
REQ-016 TOHOST SHALL accept only the first write that has d_mem_wen!=0 and d_mem_wdata[0]=1:
- That write sets tohost_valid=1 and captures tohost_data.
- Later writes are ignored until reset.
- Reads return tohost_data.
REQ-017 Any read or write outside REQ-004 SHALL return 0 on read, have no effect on write, and set bad_addr until reset.

Reset
REQ-018 When rst=1 at a clock edge, the following SHALL be 0 on the next cycle:
- d_mem_rdata, con_valid, con_data.
- FIFO count and pointers, overflow.
- cycle counter and CYCLE_HI snapshot.
- tohost_valid, tohost_data, bad_addr.
REQ-019 RAM contents SHALL NOT be reset.
REQ-020 Reset asserted while the console is mid-handshake SHALL discard all FIFO contents. Reset has priority over every concurrent write.

Structure
REQ-021 Package dmem_pkg SHALL hold the address-map constants and CON_STATUS bit indices.
REQ-022 The console FIFO SHALL be the sub-module console_fifo, with ports:
- inputs: clk, rst, push, push_data, pop.
- outputs: head_data, full, empty, count.
REQ-023 The top SHALL be at most 400 lines, with no latches, and RAM written in an inferable single-port style.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Byte-enable store: write 0xAABBCCDD with wen=1111 to 0x40, then wen=0100 with 0x00110000 -> next read of 0x40 gives 0xAA11CCDD one cycle later.
- Read-first: same cycle read and write 0x12345678 to 0x80 (old 0x0) -> rdata=0x0, following read gives 0x12345678.
- FIFO full: con_ready=0, push 9 bytes 0x41..0x49 -> status full=1, count=8, overflow=1; drain with con_ready=1 -> 0x41..0x48 in order; then empty=1.
- Push+pop at full, same cycle -> count stays 8, new byte accepted, overflow unchanged.
- Cycle atomicity: force counter to 0x0000_0000_FFFF_FFFE, read LO then HI -> HI=0x0 even after lo wraps.
- TOHOST plus bad address: write 0x1 then 0x3 -> tohost_valid=1, tohost_data=0x1; read 0x2000_0000 -> rdata=0, bad_addr=1; rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Address map and CON_STATUS layout shared by the data-memory responder and its bench.
package dmem_pkg;

  localparam logic [31:0] ADDR_CON_TX     = 32'h1000_0000;
  localparam logic [31:0] ADDR_CON_STATUS = 32'h1000_0004;
  localparam logic [31:0] ADDR_CYCLE_LO   = 32'h1000_0008;
  localparam logic [31:0] ADDR_CYCLE_HI   = 32'h1000_000C;
  localparam logic [31:0] ADDR_TOHOST     = 32'h1000_0010;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 4;

  // Word-granular match: byte offset bits never select a register.
  function automatic logic word_match(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:2] == base[31:2];
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Console byte FIFO; head is shown only when non-empty so it reads 0 after reset.
module console_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? 8'h00 : mem[rd_ptr];
  assign count     = cnt;

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-port responder: word RAM, console FIFO, 64-bit cycle counter and TOHOST.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_mem_addr,
  input  logic [31:0] d_mem_wdata,
  input  logic [3:0]  d_mem_wen,
  output logic [31:0] d_mem_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
  output logic        bad_addr
);

  localparam int unsigned RAM_AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram [DEPTH_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_q;
  logic              rd_ram_q;
  logic [31:0]       mmio_q;
  logic [31:0]       rd_mmio;
  logic [31:0]       status_word;
  logic [3:0]        cnt_sat;

  logic sel_ram, sel_tx, sel_status, sel_lo, sel_hi, sel_tohost, sel_bad;
  logic wr;

  logic [63:0] cyc_q;
  logic [31:0] hi_snap_q;
  logic        ovf_q;

  logic             fifo_push, fifo_pop, push_req, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic unused_ok;
  assign unused_ok = ^d_mem_addr[1:0];

  assign wr      = |d_mem_wen;
  assign ram_idx = d_mem_addr[RAM_AW+1:2];

  // Address decode; anything not claimed here is an unmapped access.
  always_comb begin
    sel_ram    = {2'b00, d_mem_addr[31:2]} < 32'(DEPTH_WORDS);
    sel_tx     = word_match(d_mem_addr, ADDR_CON_TX);
    sel_status = word_match(d_mem_addr, ADDR_CON_STATUS);
    sel_lo     = word_match(d_mem_addr, ADDR_CYCLE_LO);
    sel_hi     = word_match(d_mem_addr, ADDR_CYCLE_HI);
    sel_tohost = word_match(d_mem_addr, ADDR_TOHOST);
    sel_bad    = !(sel_ram || sel_tx || sel_status || sel_lo || sel_hi || sel_tohost);
  end

  // Single-port RAM, read-first, byte-enabled; writes blocked during reset.
  always_ff @(posedge clk) begin
    if (!rst && wr && sel_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (d_mem_wen[i]) ram[ram_idx][8*i +: 8] <= d_mem_wdata[8*i +: 8];
      end
    end
    ram_q <= ram[ram_idx];
  end

  assign push_req  = sel_tx && d_mem_wen[0];
  assign fifo_pop  = con_valid && con_ready;
  assign fifo_push = push_req && (!fifo_full || fifo_pop);
  assign con_valid = !fifo_empty;

  console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (d_mem_wdata[7:0]),
    .pop       (fifo_pop),
    .head_data (con_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    cnt_sat = 4'hF;
    if (32'(fifo_count) <= 32'd15) cnt_sat = 4'(fifo_count);
  end

  always_comb begin
    status_word             = '0;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_OVF]   = ovf_q;
    status_word[STAT_CNT_LSB +: STAT_CNT_W] = cnt_sat;
  end

  always_comb begin
    rd_mmio = '0;
    if (sel_status)      rd_mmio = status_word;
    else if (sel_lo)     rd_mmio = cyc_q[31:0];
    else if (sel_hi)     rd_mmio = hi_snap_q;
    else if (sel_tohost) rd_mmio = tohost_data;
  end

  // Read-return path: RAM and register reads are registered separately, then steered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ram_q <= 1'b0;
      mmio_q   <= '0;
    end else begin
      rd_ram_q <= sel_ram;
      mmio_q   <= rd_mmio;
    end
  end

  assign d_mem_rdata = rd_ram_q ? ram_q : mmio_q;

  // Cycle counter; a LO read freezes the matching HI half for a later HI read.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q     <= '0;
      hi_snap_q <= '0;
    end else begin
      cyc_q <= cyc_q + 64'd1;
      if (sel_lo) hi_snap_q <= cyc_q[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q        <= 1'b0;
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
      bad_addr     <= 1'b0;
    end else begin
      if (push_req && fifo_full && !fifo_pop)
        ovf_q <= 1'b1;
      else if (sel_status && d_mem_wen[0] && d_mem_wdata[STAT_OVF])
        ovf_q <= 1'b0;
      if (sel_tohost && wr && d_mem_wdata[0] && !tohost_valid) begin
        tohost_valid <= 1'b1;
        tohost_data  <= d_mem_wdata;
      end
      if (sel_bad) bad_addr <= 1'b1;
    end
  end

endmodule
